vjtag_stream_tx: RTL and testbench
==================================

# vjtag_stream_tx

Readback transmitter for the virtual JTAG link. It carries data from the system clock domain to the host. The block accepts words from on-chip producers over a valid/ready handshake and buffers them in a small FIFO. When the host scans the READ or STATUS virtual instruction, it returns words LSB-first on `tdo`. JTAG signals are oversampled in `clk`, so the whole block runs on one clock; its `tdo` feeds the `vjtag` hub alongside the existing LED write client.

## Interface
- `DATA_W`, 32, payload word width
- `FIFO_DEPTH`, 4, buffer depth in words; must be a power of 2 and ≥ 2
- `clk`  in  1  system clock; all state is clocked here
- `reset`  in  1  asynchronous, active-high reset
- `tck`  in  1  virtual JTAG TCK from the hub; asynchronous to `clk`
- `ir_in`  in  2  virtual IR from the hub
- `virtual_state_cdr`  in  1  hub Capture-DR state flag
- `virtual_state_sdr`  in  1  hub Shift-DR state flag
- `tdo`  out  1  serial data to the hub, registered
- `in_data`  in  DATA_W  producer word
- `in_valid`  in  1  producer word valid
- `in_ready`  out  1  FIFO not full
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- **Input sync:** `tck`, `ir_in`, `cdr` and `sdr` each pass through an identical 2-flop synchronizer.
  - `tck_r` = the synchronized `tck`, delayed one further clk.
  - Rising event: synchronized `tck`=1 and `tck_r`=0. Falling event: the inverse.
  - `ir` and the state flags are taken from the delayed copy, i.e. the TAP state before the edge.
- **Capture (rising event, `cdr`=1):**
  - IR_READ with FIFO non-empty: shift register `sr[DATA_W:0]` loads {head, 1'b1} and the FIFO pops.
  - IR_READ with FIFO empty: `sr` loads 0 (valid bit 0).
  - IR_STATUS: `sr` loads `level`, zero-extended. No pop.
- **Shift (rising event, `sdr`=1, IR ∈ {READ, STATUS}):** `sr` <= {1'b0, `sr[DATA_W:1]`}. `tdi` is ignored.
- **Output (falling event):** `tdo` <= `sr[0]` when IR ∈ {READ, STATUS}, otherwise 0. `tdo` is held between events. The top level ORs this `tdo` with the LED client's `tdo`.
- **Scan length:** the host scans DATA_W+1 bits, valid first, then data LSB first.
  - Over-scanning returns 0s.
  - A short scan discards the remaining bits; the popped word is lost.
- **FIFO:**
  - `in_ready` = `level` != FIFO_DEPTH.
  - Push when `in_valid` && `in_ready`.
  - Full with a pop in the same clk: no push that clk; `in_ready` rises the next clk.
  - Empty with a push in the same clk as a capture: the capture returns valid=0 and the word is retained.
  - Pointers wrap modulo FIFO_DEPTH.
- **IR codes:** the LED client's IR (2'b01) and IR 2'b00 never pop and keep `tdo` at 0.

## Timing
- **Reset values:** `tdo`=0, `sr`=0, `level`=0, `in_ready`=1, pointers 0, synchronizers 0. Pushes are ignored while `reset` is high.
- **Reset mid-scan:** `tdo` drops to 0 asynchronously and the remainder of the scan reads 0. Buffered words are lost.
- **Clock ratio:** `clk` ≥ 8× tck frequency. tck high and low phases must each be ≥ 3 clk periods.
- **`tdo` latency:** `tdo` changes 3 clk after the tck falling edge at the input (2 sync + 1 register). It is valid well before the next rising edge.
- **`level` latency:** updates 1 clk after a push or pop.
- **Pop latency:** a pop occurs 3 clk after the capturing tck rising edge.
- **`ir_in` changes:** allowed only in IR-update states; the IR is sampled per edge with no extra latching.

## Structure
- Package `vjtag_pkg` holds:
  - IR codes IR_LEDS=2'b01, IR_READ=2'b10, IR_STATUS=2'b11.
  - `IR_W`=2.
- The LED client uses the same package.
- Sub-module `vjtag_stream_fifo`: synchronous FIFO with parameters DATA_W and FIFO_DEPTH, push/pop ports, `level`, `full` and `empty`.
- The synchronizers and the edge detector stay inline.

## Test plan
- **Empty read:** reset, no pushes, IR_READ capture plus a 33-bit scan -> all 33 bits 0; `level` stays 0.
- **Single word:** push 0xDEADBEEF, then IR_READ scan -> bit0=1, bits 32:1 = 0xDEADBEEF LSB first; `level` goes 1 -> 0 three clk after the capture edge.
- **Backpressure:** push 5 words (1..5) at depth 4 -> `in_ready`=0 after the 4th and word 5 is held. One READ scan returns word 1, `in_ready` rises, and word 5 is accepted. Four further scans return 2, 3, 4, 5 in order.
- **Status:** with 3 words buffered, an IR_STATUS scan -> value 3 and `level` still 3. An IR_LEDS scan -> `tdo` constantly 0 with no pop.
- **Push coincident with capture:** on an empty FIFO, push in the same clk as the capture pop -> scan returns valid=0; `level`=1 afterward, and the next scan returns the word.
- **Reset mid-scan:** assert `reset` after bit 10 of a READ scan -> `tdo`=0 immediately, remaining bits 0; `level`=0 and `in_ready`=1 after release.

Source files
------------

// File: rtl/vjtag_pkg.sv
// Shared definitions for the virtual JTAG hub clients (LED writer, stream readback).
package vjtag_pkg;

    localparam int IR_W = 2;

    localparam logic [IR_W-1:0] IR_IDLE   = 2'b00;
    localparam logic [IR_W-1:0] IR_LEDS   = 2'b01;
    localparam logic [IR_W-1:0] IR_READ   = 2'b10;
    localparam logic [IR_W-1:0] IR_STATUS = 2'b11;

    // True for the instructions that route the readback shift register to tdo.
    function automatic logic ir_is_stream(input logic [IR_W-1:0] ir);
        return (ir == IR_READ) || (ir == IR_STATUS);
    endfunction

endpackage

// File: rtl/vjtag_stream_fifo.sv
// Small synchronous FIFO buffering producer words for the JTAG readback path.
module vjtag_stream_fifo #(
    parameter  int DATA_W     = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int LVL_W      = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q,  level_d;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == {LVL_W{1'b0}});
    assign level = level_q;
    assign head  = mem_q[rd_ptr_q];

    // Qualify requests and compute next pointers/occupancy; pointers wrap with their width.
    always_comb begin
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are meaningless until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/vjtag_stream_tx.sv
// Virtual JTAG readback transmitter: buffers producer words and returns them
// LSB-first on tdo when the host scans the READ or STATUS instruction.
// JTAG inputs are oversampled in clk, so everything runs on one clock.
module vjtag_stream_tx
    import vjtag_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tck,
    input  logic [IR_W-1:0]               ir_in,
    input  logic                          virtual_state_cdr,
    input  logic                          virtual_state_sdr,
    output logic                          tdo,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int SR_W   = DATA_W + 1;
    localparam int SYNC_W = IR_W + 3;

    // Bundle layout: {tck, ir, cdr, sdr}
    logic [SYNC_W-1:0] sync_in_s;
    logic [SYNC_W-1:0] meta_q;
    logic [SYNC_W-1:0] sync_q;
    logic [SYNC_W-1:0] dly_q;

    logic              tck_s;
    logic              tck_r_s;
    logic [IR_W-1:0]   ir_r_s;
    logic              cdr_r_s;
    logic              sdr_r_s;
    logic              rise_s;
    logic              fall_s;

    logic [SR_W-1:0]   sr_q, sr_d;
    logic              tdo_q, tdo_d;
    logic              pop_s;
    logic              push_s;

    logic [DATA_W-1:0] head_s;
    logic [LVL_W-1:0]  level_s;
    logic              full_s;
    logic              empty_s;

    assign sync_in_s = {tck, ir_in, virtual_state_cdr, virtual_state_sdr};

    // Two-flop synchronizer plus one delay stage shared by all JTAG inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= {SYNC_W{1'b0}};
            sync_q <= {SYNC_W{1'b0}};
            dly_q  <= {SYNC_W{1'b0}};
        end else begin
            meta_q <= sync_in_s;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    // IR and TAP flags come from the delayed copy so they reflect the state before the edge.
    assign tck_s   = sync_q[SYNC_W-1];
    assign tck_r_s = dly_q[SYNC_W-1];
    assign ir_r_s  = dly_q[2 +: IR_W];
    assign cdr_r_s = dly_q[1];
    assign sdr_r_s = dly_q[0];
    assign rise_s  = tck_s && !tck_r_s;
    assign fall_s  = !tck_s && tck_r_s;

    assign in_ready = !full_s;
    assign push_s   = in_valid && !full_s;
    assign level    = level_s;
    assign tdo      = tdo_q;

    // Capture/shift on tck rise; drive tdo on tck fall.
    always_comb begin
        sr_d  = sr_q;
        pop_s = 1'b0;
        tdo_d = tdo_q;
        if (rise_s && ir_is_stream(ir_r_s)) begin
            if (cdr_r_s) begin
                if (ir_r_s == IR_READ) begin
                    // Occupancy is registered, so a same-clk push still reads as empty.
                    if (!empty_s) begin
                        sr_d  = {head_s, 1'b1};
                        pop_s = 1'b1;
                    end else begin
                        sr_d  = {SR_W{1'b0}};
                    end
                end else begin
                    sr_d = SR_W'(level_s);
                end
            end else if (sdr_r_s) begin
                sr_d = {1'b0, sr_q[SR_W-1:1]};
            end else begin
                sr_d = sr_q;
            end
        end else begin
            sr_d = sr_q;
        end
        if (fall_s) begin
            tdo_d = ir_is_stream(ir_r_s) ? sr_q[0] : 1'b0;
        end else begin
            tdo_d = tdo_q;
        end
    end

    // Shift register and output flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= {SR_W{1'b0}};
            tdo_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            tdo_q <= tdo_d;
        end
    end

    vjtag_stream_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (in_data),
        .pop       (pop_s),
        .head      (head_s),
        .level     (level_s),
        .full      (full_s),
        .empty     (empty_s)
    );

endmodule

// File: tb/tb_vjtag_stream_tx.sv
// Directed bench for vjtag_stream_tx: emulates host scans with a slow tck
// (5 clk per phase) and checks returned bits, FIFO level and in_ready.
module tb_vjtag_stream_tx;
    import vjtag_pkg::*;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        tck      = 1'b0;
    logic [1:0]  ir_in    = 2'b00;
    logic        cdr      = 1'b0;
    logic        sdr      = 1'b0;
    logic        tdo;
    logic [31:0] in_data  = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  level;

    int          n_vec = 0;
    int          n_err = 0;
    logic [2:0]  cap_lvl [5];
    logic        cap_rdy [5];
    logic [63:0] bits;

    always #5 clk = ~clk;

    vjtag_stream_tx #(
        .DATA_W     (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .tck               (tck),
        .ir_in             (ir_in),
        .virtual_state_cdr (cdr),
        .virtual_state_sdr (sdr),
        .tdo               (tdo),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .level             (level)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic half_phase();
        repeat (5) @(negedge clk);
    endtask

    task automatic push_word(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Capture-DR then nbits Shift-DR bits; optional push in the capture clk
    // and optional reset right after bit rst_at has been sampled.
    task automatic scan(input logic [1:0] ir, input int nbits, input bit coinc,
                        input logic [31:0] cw, input int rst_at, output logic [63:0] b);
        b     = 64'h0;
        ir_in = ir;
        cdr   = 1'b1;
        sdr   = 1'b0;
        half_phase();
        tck = 1'b1;
        cdr = 1'b0;
        sdr = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cap_lvl[k] = level;
            cap_rdy[k] = in_ready;
            if (coinc && k == 1) begin
                in_valid = 1'b1;
                in_data  = cw;
            end else if (coinc && k == 2) begin
                in_valid = 1'b0;
            end
        end
        for (int i = 0; i < nbits; i++) begin
            tck = 1'b0;
            half_phase();
            b[i] = tdo;
            if (i == rst_at) begin
                reset = 1'b1;
                #1;
                chk("rst_tdo_async", {63'd0, tdo}, 64'h0);
                repeat (3) @(negedge clk);
                reset = 1'b0;
                repeat (4) @(negedge clk);
            end
            tck = 1'b1;
            sdr = (i < nbits - 1);
            half_phase();
        end
        tck = 1'b0;
        sdr = 1'b0;
        half_phase();
    endtask

    initial begin
        // Reset: pushes ignored while reset is high
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        chk("rst_level", level, 64'd0);
        chk("rst_ready", in_ready, 64'd1);
        chk("rst_tdo", tdo, 64'd0);

        // Empty read
        scan(IR_READ, 33, 1'b0, 32'h0, -1, bits);
        chk("empty_bits", bits, 64'h0);
        chk("empty_level", level, 64'd0);

        // Single word with pop latency
        push_word(32'hDEADBEEF);
        chk("single_level_pre", level, 64'd1);
        scan(IR_READ, 33, 1'b0, 32'h0, -1, bits);
        chk("single_bits", bits, {31'd0, 32'hDEADBEEF, 1'b1});
        chk("pop_lat_2clk", cap_lvl[1], 64'd1);
        chk("pop_lat_3clk", cap_lvl[2], 64'd0);
        chk("single_level_post", level, 64'd0);

        // Over-scan returns zeros
        push_word(32'h8000_0001);
        scan(IR_READ, 40, 1'b0, 32'h0, -1, bits);
        chk("overscan_bits", bits, 64'h0000_0001_0000_0003);

        // Short scan loses the rest of the popped word
        push_word(32'h0000_00A5);
        push_word(32'h0000_0077);
        scan(IR_READ, 8, 1'b0, 32'h0, -1, bits);
        chk("short_bits", bits, 64'h0000_0000_0000_004B);
        scan(IR_READ, 33, 1'b0, 32'h0, -1, bits);
        chk("after_short_bits", bits, {31'd0, 32'h77, 1'b1});

        // Backpressure
        for (int w = 1; w <= 4; w++) push_word(32'(w));
        chk("bp_level_full", level, 64'd4);
        chk("bp_ready_full", in_ready, 64'd0);
        in_valid = 1'b1;
        in_data  = 32'd5;
        repeat (3) @(negedge clk);
        chk("bp_hold_level", level, 64'd4);
        scan(IR_READ, 33, 1'b0, 32'h0, -1, bits);
        in_valid = 1'b0;
        chk("bp_word1", bits, {31'd0, 32'd1, 1'b1});
        chk("bp_ready_rise", cap_rdy[2], 64'd1);
        chk("bp_level_pop", cap_lvl[2], 64'd3);
        chk("bp_level_refill", level, 64'd4);
        for (int w = 2; w <= 5; w++) begin
            scan(IR_READ, 33, 1'b0, 32'h0, -1, bits);
            chk($sformatf("bp_word%0d", w), bits, {31'd0, 32'(w), 1'b1});
        end
        chk("bp_level_drained", level, 64'd0);

        // Status and LEDS instructions
        push_word(32'd10);
        push_word(32'd11);
        push_word(32'd12);
        scan(IR_STATUS, 33, 1'b0, 32'h0, -1, bits);
        chk("status_bits", bits, 64'd3);
        chk("status_level", level, 64'd3);
        scan(IR_LEDS, 33, 1'b0, 32'h0, -1, bits);
        chk("leds_bits", bits, 64'd0);
        chk("leds_level", level, 64'd3);
        do_reset();
        chk("reset_level", level, 64'd0);

        // Push coincident with capture on an empty FIFO
        scan(IR_READ, 33, 1'b1, 32'hCAFEF00D, -1, bits);
        chk("coinc_bits", bits, 64'h0);
        chk("coinc_level", level, 64'd1);
        scan(IR_READ, 33, 1'b0, 32'h0, -1, bits);
        chk("coinc_next_bits", bits, {31'd0, 32'hCAFEF00D, 1'b1});

        // Reset mid-scan
        push_word(32'hFFFF_FFFF);
        push_word(32'h1111_1111);
        scan(IR_READ, 33, 1'b0, 32'h0, 10, bits);
        chk("rst_mid_head", bits[10:0], 64'h7FF);
        chk("rst_mid_tail", bits >> 11, 64'h0);
        chk("rst_mid_level", level, 64'd0);
        chk("rst_mid_ready", in_ready, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
